siaminer_frame_parser: RTL and testbench



---
 rtl/siaminer_pkg.sv | 26 ++
 rtl/siaminer_byte_fifo.sv | 59 +++++
 rtl/siaminer_frame_parser.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_siaminer_frame_parser.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/siaminer_pkg.sv
// Shared constants and FSM state types for the siaminer UART framer.
package siaminer_pkg;

    localparam logic [7:0] HDR_RX    = 8'hAA;
    localparam logic [7:0] HDR_TX    = 8'h55;
    localparam logic [7:0] CMD_WORK  = 8'h00;
    localparam logic [7:0] CMD_LOOP  = 8'h01;
    localparam logic [7:0] NONCE_LEN = 8'd4;

    typedef enum logic [2:0] {
        R_IDLE,
        R_CMD,
        R_LEN,
        R_DATA,
        R_DROP
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_HDR,
        T_CMD,
        T_LEN,
        T_DATA
    } tx_state_t;

endpackage

// File: rtl/siaminer_byte_fifo.sv
// Synchronous DEPTH x 8 byte FIFO with registered full/empty flags.
module siaminer_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_d;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count_d = count + CW'(push_ok) - CW'(pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/siaminer_frame_parser.sv
// Byte framer between the UART core and siacore: parses host work/loop frames
// and emits nonce reports and loop acks.
// Optional macro SIAMINER_RX_TIMEOUT_EN adds an inter-byte rx timeout.
module siaminer_frame_parser
    import siaminer_pkg::*;
#(
    parameter int unsigned WORK_BYTES     = 88,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         new_rx_data,
    output logic [7:0]   tx_data,
    output logic         new_tx_data,
    input  logic         tx_busy,
    output logic [639:0] work,
    output logic [63:0]  target,
    output logic         work_valid,
    input  logic         nonce_found,
    input  logic [31:0]  nonce,
    output logic         rx_last_byte,
    output logic         tx_last_byte,
    output logic         frame_err
);

    localparam int unsigned WORK_W = 640;
    localparam int unsigned TGT_W  = 64;
    localparam int unsigned SH_W   = WORK_W + TGT_W - 8;

    // Reject configurations the FIFO pointers or timeout counter cannot represent.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("siaminer_frame_parser: bad FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    rx_state_t   rx_state, rx_state_d;
    logic [7:0]  rx_cmd, rx_cmd_d;
    logic [7:0]  rx_cnt, rx_cnt_d;
    logic [SH_W-1:0] sreg;
    logic        shift_c, work_done_c, push_c, rx_err_c, loop_req_c;
    logic [7:0]  pad_add_c;

    tx_state_t   tx_state, tx_state_d;
    logic [7:0]  tx_cmd, tx_cmd_d;
    logic [7:0]  tx_cnt, tx_cnt_d;
    logic [31:0] tx_nonce;
    logic        can_issue_c, issue_c, last_c, pop_c, pad_dec_c;
    logic        start_nonce_c, start_loop_c, nonce_shift_c;
    logic [7:0]  byte_c;

    logic        nonce_pend;
    logic [31:0] nonce_val;
    logic        loop_pend;
    logic [7:0]  loop_len;
    logic [8:0]  pad_cnt;

    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;

`ifdef SIAMINER_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          timeout_c;

    assign timeout_c = (rx_state != R_IDLE) && !new_rx_data
                       && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Cycles since the last rx byte while a frame is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (new_rx_data || rx_state == R_IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end
`endif

    // Rx next-state and per-byte actions.
    always_comb begin
        rx_state_d  = rx_state;
        rx_cmd_d    = rx_cmd;
        rx_cnt_d    = rx_cnt;
        shift_c     = 1'b0;
        work_done_c = 1'b0;
        push_c      = 1'b0;
        rx_err_c    = 1'b0;
        loop_req_c  = 1'b0;
        pad_add_c   = 8'd0;
        if (new_rx_data) begin
            case (rx_state)
                R_IDLE: begin
                    if (rx_data == HDR_RX) begin
                        rx_state_d = R_CMD;
                    end
                end
                R_CMD: begin
                    rx_cmd_d   = rx_data;
                    rx_state_d = R_LEN;
                end
                R_LEN: begin
                    rx_cnt_d = rx_data;
                    if (rx_data == 8'd0) begin
                        loop_req_c = (rx_cmd == CMD_LOOP);
                        rx_state_d = R_IDLE;
                    end else if (rx_cmd == CMD_WORK && rx_data == 8'(WORK_BYTES)) begin
                        rx_state_d = R_DATA;
                    end else if (rx_cmd == CMD_LOOP) begin
                        loop_req_c = 1'b1;
                        rx_state_d = R_DATA;
                    end else begin
                        rx_err_c   = 1'b1;
                        rx_state_d = R_DROP;
                    end
                end
                R_DATA: begin
                    rx_cnt_d = rx_cnt - 8'd1;
                    if (rx_cmd == CMD_WORK) begin
                        work_done_c = (rx_cnt == 8'd1);
                        shift_c     = (rx_cnt != 8'd1);
                    end else if (fifo_full) begin
                        rx_err_c  = 1'b1;
                        pad_add_c = 8'd1;
                    end else begin
                        push_c = 1'b1;
                    end
                    if (rx_cnt == 8'd1) begin
                        rx_state_d = R_IDLE;
                    end
                end
                R_DROP: begin
                    rx_cnt_d = rx_cnt - 8'd1;
                    if (rx_cnt == 8'd1) begin
                        rx_state_d = R_IDLE;
                    end
                end
                default: rx_state_d = R_IDLE;
            endcase
        end
`ifdef SIAMINER_RX_TIMEOUT_EN
        if (timeout_c) begin
            rx_state_d  = R_IDLE;
            rx_err_c    = 1'b1;
            shift_c     = 1'b0;
            work_done_c = 1'b0;
            push_c      = 1'b0;
            loop_req_c  = 1'b0;
            // Bytes the host never sent are padded so the started ack completes.
            pad_add_c   = (rx_state == R_DATA && rx_cmd == CMD_LOOP) ? rx_cnt : 8'd0;
        end
`endif
    end

    // Rx state, work shift chain and work/target outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state     <= R_IDLE;
            rx_cmd       <= 8'd0;
            rx_cnt       <= 8'd0;
            sreg         <= '0;
            work         <= '0;
            target       <= '0;
            work_valid   <= 1'b0;
            rx_last_byte <= 1'b0;
        end else begin
            rx_state   <= rx_state_d;
            rx_cmd     <= rx_cmd_d;
            rx_cnt     <= rx_cnt_d;
            work_valid <= work_done_c;
            if (shift_c) begin
                sreg <= {rx_data, sreg[SH_W-1:8]};
            end
            if (work_done_c) begin
                work   <= sreg[WORK_W-1:0];
                target <= {rx_data, sreg[SH_W-1:WORK_W]};
            end
            rx_last_byte <= (rx_state_d == R_DATA || rx_state_d == R_DROP)
                            && (rx_cnt_d == 8'd1);
        end
    end

    siaminer_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .din   (rx_data),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A strobe in the previous cycle blocks issue until tx_busy has had time to rise.
    assign can_issue_c = !tx_busy && !new_tx_data;

    // Tx next-state, frame selection and byte issue.
    always_comb begin
        tx_state_d    = tx_state;
        tx_cmd_d      = tx_cmd;
        tx_cnt_d      = tx_cnt;
        issue_c       = 1'b0;
        last_c        = 1'b0;
        byte_c        = 8'h00;
        pop_c         = 1'b0;
        pad_dec_c     = 1'b0;
        start_nonce_c = 1'b0;
        start_loop_c  = 1'b0;
        nonce_shift_c = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (nonce_pend) begin
                    start_nonce_c = 1'b1;
                    tx_cmd_d      = CMD_WORK;
                    tx_cnt_d      = NONCE_LEN;
                    tx_state_d    = T_HDR;
                end else if (loop_pend) begin
                    start_loop_c = 1'b1;
                    tx_cmd_d     = CMD_LOOP;
                    tx_cnt_d     = loop_len;
                    tx_state_d   = T_HDR;
                end
            end
            T_HDR: begin
                if (can_issue_c) begin
                    issue_c    = 1'b1;
                    byte_c     = HDR_TX;
                    tx_state_d = T_CMD;
                end
            end
            T_CMD: begin
                if (can_issue_c) begin
                    issue_c    = 1'b1;
                    byte_c     = tx_cmd;
                    tx_state_d = T_LEN;
                end
            end
            T_LEN: begin
                if (can_issue_c) begin
                    issue_c = 1'b1;
                    byte_c  = tx_cnt;
                    if (tx_cnt == 8'd0) begin
                        last_c     = 1'b1;
                        tx_state_d = T_IDLE;
                    end else begin
                        tx_state_d = T_DATA;
                    end
                end
            end
            T_DATA: begin
                if (can_issue_c) begin
                    if (tx_cmd == CMD_WORK) begin
                        issue_c       = 1'b1;
                        nonce_shift_c = 1'b1;
                        byte_c        = tx_nonce[7:0];
                    end else if (!fifo_empty) begin
                        issue_c = 1'b1;
                        pop_c   = 1'b1;
                        byte_c  = fifo_dout;
                    end else if (pad_cnt != 9'd0) begin
                        issue_c   = 1'b1;
                        pad_dec_c = 1'b1;
                    end
                end
                if (issue_c) begin
                    tx_cnt_d = tx_cnt - 8'd1;
                    if (tx_cnt == 8'd1) begin
                        last_c     = 1'b1;
                        tx_state_d = T_IDLE;
                    end
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // Tx state and registered UART-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state     <= T_IDLE;
            tx_cmd       <= 8'd0;
            tx_cnt       <= 8'd0;
            tx_nonce     <= 32'd0;
            tx_data      <= 8'd0;
            new_tx_data  <= 1'b0;
            tx_last_byte <= 1'b0;
        end else begin
            tx_state     <= tx_state_d;
            tx_cmd       <= tx_cmd_d;
            tx_cnt       <= tx_cnt_d;
            tx_data      <= byte_c;
            new_tx_data  <= issue_c;
            tx_last_byte <= last_c;
            if (start_nonce_c) begin
                tx_nonce <= nonce_val;
            end else if (nonce_shift_c) begin
                tx_nonce <= {8'h00, tx_nonce[31:8]};
            end
        end
    end

    // Pending nonce / loop-ack requests, pad credit and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_pend <= 1'b0;
            nonce_val  <= 32'd0;
            loop_pend  <= 1'b0;
            loop_len   <= 8'd0;
            pad_cnt    <= 9'd0;
            frame_err  <= 1'b0;
        end else begin
            if (nonce_found) begin
                nonce_pend <= 1'b1;
                nonce_val  <= nonce;
            end else if (start_nonce_c) begin
                nonce_pend <= 1'b0;
            end
            if (loop_req_c) begin
                loop_pend <= 1'b1;
                loop_len  <= rx_cnt_d;
            end else if (start_loop_c) begin
                loop_pend <= 1'b0;
            end
            pad_cnt   <= pad_cnt + 9'(pad_add_c) - 9'(pad_dec_c);
            frame_err <= rx_err_c || (nonce_found && nonce_pend && !start_nonce_c);
        end
    end

endmodule

// File: tb/tb_siaminer_frame_parser.sv
// Scoreboard bench for siaminer_frame_parser: stimulus pushes expected tx bytes
// and work blocks, a monitor pops and compares whenever the DUT strobes.
module tb_siaminer_frame_parser;

    logic         clk;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         new_rx_data;
    logic [7:0]   tx_data;
    logic         new_tx_data;
    logic         tx_busy;
    logic [639:0] work;
    logic [63:0]  target;
    logic         work_valid;
    logic         nonce_found;
    logic [31:0]  nonce;
    logic         rx_last_byte;
    logic         tx_last_byte;
    logic         frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;
    logic wv_prev = 1'b0;

    logic [8:0]   exp_tx[$];
    logic [703:0] exp_work[$];

    siaminer_frame_parser dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .new_rx_data  (new_rx_data),
        .tx_data      (tx_data),
        .new_tx_data  (new_tx_data),
        .tx_busy      (tx_busy),
        .work         (work),
        .target       (target),
        .work_valid   (work_valid),
        .nonce_found  (nonce_found),
        .nonce        (nonce),
        .rx_last_byte (rx_last_byte),
        .tx_last_byte (tx_last_byte),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data     = b;
        new_rx_data = 1'b1;
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
    endtask

    task automatic pulse_nonce(input logic [31:0] n);
        @(posedge clk);
        #1;
        nonce       = n;
        nonce_found = 1'b1;
        @(posedge clk);
        #1;
        nonce_found = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b, input logic last);
        exp_tx.push_back({last, b});
    endtask

    task automatic expect_nonce(input logic [31:0] n);
        push_tx(8'h55, 1'b0);
        push_tx(8'h00, 1'b0);
        push_tx(8'h04, 1'b0);
        push_tx(n[7:0], 1'b0);
        push_tx(n[15:8], 1'b0);
        push_tx(n[23:16], 1'b0);
        push_tx(n[31:24], 1'b1);
    endtask

    task automatic send_work(input bit inv, input bit expect_it);
        logic [639:0] w;
        logic [63:0]  t;
        logic [7:0]   b;
        w = '0;
        t = '0;
        for (int k = 0; k < 88; k++) begin
            b = inv ? ~8'(k) : 8'(k);
            if (k < 80) w[8*k +: 8] = b;
            else        t[8*(k-80) +: 8] = b;
        end
        if (expect_it) exp_work.push_back({t, w});
        send_byte(8'hAA);
        send_byte(8'h00);
        send_byte(8'd88);
        for (int k = 0; k < 88; k++) begin
            b = inv ? ~8'(k) : 8'(k);
            send_byte(b);
        end
    endtask

    task automatic wait_tx_drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_tx.size() != 0 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (15) @(posedge clk);
        check(name, 64'(exp_tx.size()), 64'd0);
    endtask

    // UART transmitter model: busy for 10 cycles, rising one cycle after each strobe.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (new_tx_data) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: compares every tx strobe and work_valid against the scoreboard.
    initial begin
        logic [8:0]   e;
        logic [703:0] ew;
        forever begin
            @(negedge clk);
            if (new_tx_data) begin
                check("tx_strobe_while_busy", 64'(tx_busy), 64'd0);
                n_tests++;
                if (exp_tx.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %h last %b expected no strobe", tx_data, tx_last_byte);
                end else begin
                    e = exp_tx.pop_front();
                    if ({tx_last_byte, tx_data} !== e) begin
                        n_fail++;
                        $display("FAIL tx_byte: got last=%b data=%h expected last=%b data=%h",
                                 tx_last_byte, tx_data, e[8], e[7:0]);
                    end
                end
            end
            if (work_valid) begin
                check("work_valid_width", 64'(wv_prev), 64'd0);
                n_tests++;
                if (exp_work.size() == 0) begin
                    n_fail++;
                    $display("FAIL work_unexpected: got work_valid=1 expected none");
                end else begin
                    ew = exp_work.pop_front();
                    if ({target, work} !== ew) begin
                        n_fail++;
                        $display("FAIL work_target: got %h expected %h", {target, work}, ew);
                    end
                end
            end
            wv_prev = work_valid;
            if (frame_err) err_seen++;
        end
    end

    // Global time bound.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        rx_data     = 8'h00;
        new_rx_data = 1'b0;
        nonce_found = 1'b0;
        nonce       = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_new_tx_data", 64'(new_tx_data), 64'd0);
        check("rst_work_valid", 64'(work_valid), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_target", target, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Noise before a header, then a one-byte loop frame.
        push_tx(8'h55, 1'b0); push_tx(8'h01, 1'b0); push_tx(8'h01, 1'b0); push_tx(8'h5A, 1'b1);
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h55);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h01);
        check("rx_last_byte_loop", 64'(rx_last_byte), 64'd1);
        send_byte(8'h5A);
        check("rx_last_byte_after", 64'(rx_last_byte), 64'd0);
        wait_tx_drain("loop_drain");

        // Zero-length loop frame still gets an ack.
        push_tx(8'h55, 1'b0); push_tx(8'h01, 1'b0); push_tx(8'h00, 1'b1);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h00);
        wait_tx_drain("loop0_drain");

        // Work frame with bytes 00..57.
        send_work(1'b0, 1'b1);
        check("work_valid_timing", 64'(work_valid), 64'd1);
        check("work_byte0", 64'(work[7:0]), 64'h00);
        check("work_byte79", 64'(work[639:632]), 64'h4F);
        check("target", target, 64'h5756555453525150);
        repeat (3) @(posedge clk);
        check("work_hold", 64'(work[639:632]), 64'h4F);

        // Standalone nonce report.
        expect_nonce(32'h12345678);
        pulse_nonce(32'h12345678);
        wait_tx_drain("nonce_drain");

        // Bad length work frame is dropped, next valid frame completes.
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h04);
        repeat (2) @(posedge clk);
        check("badlen_err", 64'(err_seen), 64'd1);
        send_work(1'b1, 1'b1);
        repeat (3) @(posedge clk);
        check("work2_target", target, 64'hA8A9AAABACADAEAF);

        // Nonces during a loop echo: loop completes, then latest nonce, one error.
        push_tx(8'h55, 1'b0); push_tx(8'h01, 1'b0); push_tx(8'h03, 1'b0);
        push_tx(8'h11, 1'b0); push_tx(8'h22, 1'b0); push_tx(8'h33, 1'b1);
        expect_nonce(32'h0BADF00D);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03);
        send_byte(8'h11);
        pulse_nonce(32'hCAFEBABE);
        send_byte(8'h22);
        pulse_nonce(32'h0BADF00D);
        send_byte(8'h33);
        wait_tx_drain("collision_drain");
        check("collision_err", 64'(err_seen), 64'd2);

        // Reset in the middle of a work frame.
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'd88);
        for (int k = 0; k < 40; k++) send_byte(8'(k));
        rst_n = 1'b0;
        #1;
        check("midrst_work", 64'(|work), 64'd0);
        check("midrst_target", target, 64'd0);
        check("midrst_work_valid", 64'(work_valid), 64'd0);
        check("midrst_rx_last", 64'(rx_last_byte), 64'd0);
        check("midrst_tx", 64'({new_tx_data, tx_last_byte, tx_data}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        check("midrst_no_work", 64'(exp_work.size()), 64'd0);
        check("final_err_count", 64'(err_seen), 64'd2);
        check("final_tx_queue", 64'(exp_tx.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
